// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the piso_tx transmitter.
//   state_e      - controller state encoding (2 bits)
//   DATA_W_DEF   - default parallel word width
package piso_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/piso_dp.sv
// piso_dp: datapath for piso_tx. Holds the shift register, the bit counter
// and the bit-period divider, and flags the final clock of the final bit.
//   clk, rst_sh  - clock, async active-high reset
//   clr_i        - synchronous clear of all state (highest priority)
//   load_i       - load pi_i into the shift register, zero counters
//   shift_en_i   - transfer in progress: advance divider / shift on period end
//   pi_i         - parallel word
//   sh0_o        - current serial bit (shift register LSB)
//   last_o       - bit_cnt==DATA_W-1 and div_cnt==BIT_DIV-1
module piso_dp #(
  parameter int DATA_W  = 8,
  parameter int BIT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_sh,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [DATA_W-1:0] pi_i,
  output logic              sh0_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(DATA_W);
  // BIT_DIV=1 still needs a 1-bit divider so the compare below is well-formed.
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DATA_W-1:0] sh_q,  sh_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              period_end;

  assign period_end = (div_q == DIV_LAST);
  assign last_o     = period_end && (bit_q == BIT_LAST);
  assign sh0_o      = sh_q[0];

  always_comb begin
    sh_d  = sh_q;
    bit_d = bit_q;
    div_d = div_q;
    if (clr_i) begin
      sh_d  = '0;
      bit_d = '0;
      div_d = '0;
    end else if (load_i) begin
      sh_d  = pi_i;
      bit_d = '0;
      div_d = '0;
    end else if (shift_en_i) begin
      if (period_end) begin
        div_d = '0;
        sh_d  = {1'b0, sh_q[DATA_W-1:1]};
        bit_d = bit_q + CNT_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_sh) begin
    if (rst_sh) begin
      sh_q  <= '0;
      bit_q <= '0;
      div_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bit_q <= bit_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter. Accepts a DATA_W-bit word on
// start while ready, sends it LSB-first on so qualified by so_en (one bit
// per BIT_DIV clocks), then pulses done for one cycle.
//   clk, rst_sh  - clock, async active-high reset
//   start, pi    - send request and parallel word (sampled on accepting edge)
//   abort        - synchronous kill of any transfer, no done pulse
//   ready, busy  - can accept start / transfer in progress
//   so, so_en    - serial bit and its valid (receiver shift enable)
//   done         - one-cycle pulse after the last bit
module piso_tx
  import piso_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BIT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_sh,
  input  logic              start,
  input  logic [DATA_W-1:0] pi,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              so,
  output logic              so_en,
  output logic              done
);

  state_e state_q, state_d;
  logic   load, clr, shift_en, last, sh0;

  piso_dp #(
    .DATA_W (DATA_W),
    .BIT_DIV(BIT_DIV)
  ) u_dp (
    .clk       (clk),
    .rst_sh    (rst_sh),
    .clr_i     (clr),
    .load_i    (load),
    .shift_en_i(shift_en),
    .pi_i      (pi),
    .sh0_o     (sh0),
    .last_o    (last)
  );

  always_ff @(posedge clk or posedge rst_sh) begin
    if (rst_sh) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: if (last) state_d = ST_DONE;
        // Re-accepting here keeps the inter-word so_en gap to one cycle.
        ST_DONE: begin
          if (start) begin
            load    = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign shift_en = (state_q == ST_SHIFT);
  assign busy     = shift_en;
  assign so_en    = shift_en;
  assign so       = shift_en & sh0;
  assign done     = (state_q == ST_DONE);
  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_sh;
  logic       start, abort;
  logic [7:0] pi;
  logic       ready, busy, so, so_en, done;

  logic       start3;
  logic [7:0] pi3;
  logic       ready3, busy3, so3, so_en3, done3;

  logic [7:0] rx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_tx #(.DATA_W(8), .BIT_DIV(1)) dut (
    .clk(clk), .rst_sh(rst_sh), .start(start), .pi(pi), .abort(abort),
    .ready(ready), .busy(busy), .so(so), .so_en(so_en), .done(done)
  );

  piso_tx #(.DATA_W(8), .BIT_DIV(3)) dut3 (
    .clk(clk), .rst_sh(rst_sh), .start(start3), .pi(pi3), .abort(1'b0),
    .ready(ready3), .busy(busy3), .so(so3), .so_en(so_en3), .done(done3)
  );

  // Downstream receiver: shifts right, serial bit enters the MSB.
  always_ff @(posedge clk) if (so_en) rx <= {so, rx[7:1]};

  task automatic test_reset;
    rst_sh = 1'b1; start = 1'b0; abort = 1'b0; pi = '0; start3 = 1'b0; pi3 = '0;
    #12;
    checks++;
    if ({ready, busy, so, so_en, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_asserted got=%b exp=10000", {ready, busy, so, so_en, done});
    end
    @(negedge clk); rst_sh = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, busy, so, so_en, done, ready3, busy3, so_en3, done3} !== 9'b100001000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=100001000", i,
                 {ready, busy, so, so_en, done, ready3, busy3, so_en3, done3});
      end
    end
  endtask

  // Checks the 8 bits of w on so/so_en, starting at the current negedge.
  task automatic check_word(input logic [7:0] w, input string tag);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so_en !== 1'b1 || so !== w[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL %s bit%0d so_en=%b so=%b done=%b exp so_en=1 so=%b done=0",
                 tag, i, so_en, so, done, w[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic;
    pi = 8'hA5; start = 1'b1;
    @(negedge clk); start = 1'b0; pi = 8'h00;
    check_word(8'hA5, "basic");
    checks++;
    if (done !== 1'b1 || so_en !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_done done=%b so_en=%b ready=%b exp 1 0 1", done, so_en, ready);
    end
    checks++;
    if (rx !== 8'hA5) begin
      failures++;
      $display("FAIL basic_rx got=%h exp=a5", rx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || so_en !== 1'b0) begin
      failures++;
      $display("FAIL basic_after done=%b so_en=%b exp 0 0", done, so_en);
    end
  endtask

  task automatic test_back_to_back;
    pi = 8'h3C; start = 1'b1;
    @(negedge clk); pi = 8'hC3;
    check_word(8'h3C, "b2b_w0");
    checks++;
    if (done !== 1'b1 || so_en !== 1'b0 || ready !== 1'b1 || rx !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_gap done=%b so_en=%b ready=%b rx=%h exp 1 0 1 3c",
               done, so_en, ready, rx);
    end
    @(negedge clk); start = 1'b0; pi = 8'h00;
    check_word(8'hC3, "b2b_w1");
    checks++;
    if (done !== 1'b1 || rx !== 8'hC3) begin
      failures++;
      $display("FAIL b2b_end done=%b rx=%h exp 1 c3", done, rx);
    end
    @(negedge clk);
  endtask

  task automatic test_bit_div3;
    int n;
    pi3 = 8'h01; start3 = 1'b1;
    @(negedge clk); start3 = 1'b0; pi3 = 8'h00;
    n = 0;
    while (so_en3 === 1'b1 && n < 40) begin
      checks++;
      if (so3 !== (n < 3 ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL div3_so cyc=%0d got=%b exp=%b", n, so3, (n < 3));
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 24) begin
      failures++;
      $display("FAIL div3_len got=%0d exp=24", n);
    end
    checks++;
    if (done3 !== 1'b1) begin
      failures++;
      $display("FAIL div3_done got=%b exp=1", done3);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int dones;
    pi = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin start = 1'b1; pi = 8'hFF; end
      if (i == 4) begin start = 1'b0; pi = 8'h00; end
      checks++;
      if (so_en !== 1'b1 || so !== 1'b0) begin
        failures++;
        $display("FAIL busy_ign bit%0d so_en=%b so=%b exp 1 0", i, so_en, so);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      checks++;
      if (so_en !== 1'b0) begin
        failures++;
        $display("FAIL busy_tail cyc=%0d so_en=%b exp 0", i, so_en);
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL busy_dones got=%0d exp=1", dones);
    end
  endtask

  task automatic test_abort_reset;
    pi = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if ({ready, busy, so_en, done} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=1000", {ready, busy, so_en, done});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || so_en !== 1'b0) begin
        failures++;
        $display("FAIL abort_nodone cyc=%0d done=%b so_en=%b exp 0 0", i, done, so_en);
      end
    end
    pi = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_sh = 1'b1;
    #1;
    checks++;
    if ({ready, busy, so, so_en, done} !== 5'b10000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=10000", {ready, busy, so, so_en, done});
    end
    @(negedge clk); rst_sh = 1'b0;
    @(negedge clk);
    pi = 8'h5A; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_word(8'h5A, "post_reset");
    checks++;
    if (done !== 1'b1 || rx !== 8'h5A) begin
      failures++;
      $display("FAIL post_reset_end done=%b rx=%h exp 1 5a", done, rx);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bit_div3();
    test_start_while_busy();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter with a controller FSM, a bit counter and a bit-period divider.
- Accepts a DATA_W-bit word on a start handshake and emits it LSB-first on so, qualified by so_en, one bit per BIT_DIV clocks.
- so_en drives the shift-enable of the downstream 8-bit serial-in shift receiver, which shifts right with si entering the MSB; a sent word therefore reassembles unchanged.
- Raises done for one cycle when the word is sent.

Parameters:
DATA_W, 8, word width; must be >= 2
BIT_DIV, 1, clocks per serial bit; must be >= 1
CNT_W, $clog2(DATA_W), bit-counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_sh  input  1  reset, asynchronous, active-high
start  input  1  request to send pi; honoured only while ready=1
pi  input  DATA_W  parallel word; sampled on the accepting edge
abort  input  1  synchronous clear; kills any transfer
ready  output  1  block can accept start this cycle
busy  output  1  transfer in progress (SHIFT state)
so  output  1  serial data, LSB first
so_en  output  1  so is valid this cycle; receiver shifts when high
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (rst_sh=1, any time, including mid-transfer):
  - state=IDLE; shift reg, bit_cnt, div_cnt = 0.
  - Outputs: ready=1, busy=0, so=0, so_en=0, done=0.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- ready = (state==IDLE) or (state==DONE). busy = (state==SHIFT).
- so = sh[0] when in SHIFT, else 0. so_en = (state==SHIFT). done = (state==DONE).
- IDLE:
  - start=1 -> sh<=pi, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - Otherwise stay.
- SHIFT:
  - div_cnt increments each cycle.
  - When div_cnt==BIT_DIV-1: div_cnt<=0, sh<={1'b0, sh[DATA_W-1:1]}, bit_cnt<=bit_cnt+1.
  - last = (bit_cnt==DATA_W-1) and (div_cnt==BIT_DIV-1). When last=1, go to DONE.
  - start is ignored in SHIFT; pi changes have no effect on the word in flight.
- DONE (exactly one cycle):
  - start=1 -> load pi, clear counters, go to SHIFT. This gives back-to-back words with a single-cycle so_en gap.
  - Otherwise go to IDLE.
- Timing, start accepted at edge k (BIT_DIV=1):
  - so_en=1 during cycles k+1..k+8, carrying bits 0..7.
  - done=1 in cycle k+9.
  - General case: so_en high for DATA_W*BIT_DIV cycles; done follows the last so_en cycle.
- Each bit's value is held stable on so for all BIT_DIV cycles of its period.
- abort=1 (synchronous, highest priority after reset):
  - Next state IDLE; counters and sh cleared.
  - No done pulse; start in the same cycle is ignored.
- Counters wrap naturally; bit_cnt never exceeds DATA_W-1 because exit occurs on last.
- Inputs are sampled on the rising edge only; there is no combinational path from start to outputs.

Decomposition:
- Shared package piso_pkg holds:
  - state typedef/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default width constant 8.
- One natural sub-module: piso_dp (datapath), containing the shift register, bit_cnt, div_cnt and the last-flag.
- The top level holds the FSM and output decode.
- The controller drives load, shift_en, clr; the datapath returns last.

Test Plan:
1. Reset then idle: rst_sh pulse, no start -> ready=1, busy=0, so=0, so_en=0, done=0 for 20 cycles.
2. Basic send, BIT_DIV=1, pi=8'hA5, start at edge k:
   - so over cycles k+1..k+8 = 1,0,1,0,0,1,0,1 with so_en=1;
   - done=1 at k+9 only;
   - loopback receiver word = 8'hA5.
3. Back-to-back: pi=8'h3C then 8'hC3, start held high:
   - second word accepted in the DONE cycle;
   - so_en low exactly one cycle between words;
   - receiver captures 8'h3C then 8'hC3.
4. BIT_DIV=3, pi=8'h01 -> so=1 for first 3 so_en cycles, 0 for the remaining 21; total so_en cycles = 24.
5. Start while busy: start pulse with pi=8'hFF at cycle k+4 during an 8'h00 transfer -> ignored; so stays 0 for all 8 bits; one done pulse.
6. Abort and reset mid-transfer:
   - abort at bit 3 -> IDLE next cycle, so_en=0, no done;
   - rst_sh asserted asynchronously mid-bit -> all outputs at reset values immediately;
   - a new start for pi=8'h5A afterwards completes correctly.
